// File: rtl/rc4_pkg.sv
// Shared types and widths for the RC4 phase sequencer and its S-memory port mux.
package rc4_pkg;

   localparam int unsigned KEY_W  = 24;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      ENG_RST,
      INIT,
      KSA,
      PRGA,
      DONE,
      ERROR
   } phase_e;

endpackage

// File: rtl/rc4_mem_mux.sv
// Combinational 3:1 S-memory port mux; idle phases drive an all-zero, non-writing port.
module rc4_mem_mux import rc4_pkg::*; (
   input  logic [2:0]        phase,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic [DATA_W-1:0] init_wrdata,
   input  logic              init_wren,
   input  logic [ADDR_W-1:0] ksa_addr,
   input  logic [DATA_W-1:0] ksa_wrdata,
   input  logic              ksa_wren,
   input  logic [ADDR_W-1:0] prga_addr,
   input  logic [DATA_W-1:0] prga_wrdata,
   input  logic              prga_wren,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wrdata,
   output logic              mem_wren
);

   always_comb begin
      mem_addr   = '0;
      mem_wrdata = '0;
      mem_wren   = 1'b0;
      case (phase)
         INIT: begin
            mem_addr   = init_addr;
            mem_wrdata = init_wrdata;
            mem_wren   = init_wren;
         end
         KSA: begin
            mem_addr   = ksa_addr;
            mem_wrdata = ksa_wrdata;
            mem_wren   = ksa_wren;
         end
         PRGA: begin
            mem_addr   = prga_addr;
            mem_wrdata = prga_wrdata;
            mem_wren   = prga_wren;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/rc4_phase_ctrl.sv
// RC4 decrypt sequencer: restarts engines, runs init -> KSA -> PRGA with a per-phase
// watchdog, and routes the single S-memory port to the active engine.
module rc4_phase_ctrl import rc4_pkg::*; #(
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned RST_CYCLES     = 2,
   parameter int unsigned CNT_W          = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [KEY_W-1:0]  key,
   output logic [KEY_W-1:0]  key_q,
   output logic              eng_rst_n,
   output logic              init_go,
   output logic              ksa_go,
   output logic              prga_go,
   input  logic              init_done,
   input  logic              ksa_done,
   input  logic              prga_done,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic [DATA_W-1:0] init_wrdata,
   input  logic              init_wren,
   input  logic [ADDR_W-1:0] ksa_addr,
   input  logic [DATA_W-1:0] ksa_wrdata,
   input  logic              ksa_wren,
   input  logic [ADDR_W-1:0] prga_addr,
   input  logic [DATA_W-1:0] prga_wrdata,
   input  logic              prga_wren,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wrdata,
   output logic              mem_wren,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [2:0]        phase
);

   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] RstLast     = CNT_W'(RST_CYCLES - 1);

   phase_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [KEY_W-1:0]   key_d;
   logic               eng_rst_n_q, eng_rst_n_d;
   logic [2:0]         go_q, go_d;  // {prga, ksa, init}
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               error_q, error_d;
   logic               active_done;

   // Only the running engine's done counts; the others may hold stale sticky flags.
   assign active_done = ((state_q == INIT) && init_done) ||
                        ((state_q == KSA)  && ksa_done)  ||
                        ((state_q == PRGA) && prga_done);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      key_d       = key_q;
      eng_rst_n_d = eng_rst_n_q;
      go_d        = go_q;
      busy_d      = busy_q;
      done_d      = done_q;
      error_d     = error_q;
      case (state_q)
         IDLE, DONE, ERROR: begin
            if (start) begin
               state_d     = ENG_RST;
               key_d       = key;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               error_d     = 1'b0;
               eng_rst_n_d = 1'b0;
               go_d        = 3'b000;
               cnt_d       = '0;
            end
         end
         ENG_RST: begin
            if (cnt_q == RstLast) begin
               state_d     = INIT;
               eng_rst_n_d = 1'b1;
               go_d        = 3'b001;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         INIT, KSA, PRGA: begin
            cnt_d = cnt_q + 1'b1;
            // done is tested first so a done on the final watchdog cycle still advances
            if (active_done) begin
               cnt_d = '0;
               if (state_q == INIT) begin
                  state_d = KSA;
                  go_d    = 3'b010;
               end else if (state_q == KSA) begin
                  state_d = PRGA;
                  go_d    = 3'b100;
               end else begin
                  state_d = DONE;
                  go_d    = 3'b000;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end else if (cnt_q == TimeoutLast) begin
               state_d = ERROR;
               go_d    = 3'b000;
               busy_d  = 1'b0;
               error_d = 1'b1;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d     = IDLE;
            cnt_d       = '0;
            eng_rst_n_d = 1'b1;
            go_d        = 3'b000;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            error_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         key_q       <= '0;
         eng_rst_n_q <= 1'b1;
         go_q        <= 3'b000;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         key_q       <= key_d;
         eng_rst_n_q <= eng_rst_n_d;
         go_q        <= go_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign eng_rst_n = eng_rst_n_q;
   assign init_go   = go_q[0];
   assign ksa_go    = go_q[1];
   assign prga_go   = go_q[2];
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign phase     = state_q;

   rc4_mem_mux u_mem_mux (
      .phase       (state_q),
      .init_addr   (init_addr),
      .init_wrdata (init_wrdata),
      .init_wren   (init_wren),
      .ksa_addr    (ksa_addr),
      .ksa_wrdata  (ksa_wrdata),
      .ksa_wren    (ksa_wren),
      .prga_addr   (prga_addr),
      .prga_wrdata (prga_wrdata),
      .prga_wren   (prga_wren),
      .mem_addr    (mem_addr),
      .mem_wrdata  (mem_wrdata),
      .mem_wren    (mem_wren)
   );

endmodule

// File: tb/tb_rc4_phase_ctrl.sv
// Scoreboard bench for rc4_phase_ctrl: stimulus queues expected phase transitions and
// probes; monitors compare on each observed transition and on each probe request.
module tb_rc4_phase_ctrl;
   import rc4_pkg::*;

   localparam int unsigned TO      = 16;
   localparam int unsigned RST_CYC = 2;

   localparam logic [7:0] IA = 8'h11, IW = 8'hA1;
   localparam logic [7:0] KA = 8'h22, KW = 8'hB2;
   localparam logic [7:0] PA = 8'h33, PW = 8'hC3;

   logic        clk, rst_n, start;
   logic [23:0] key, key_q;
   logic        eng_rst_n, init_go, ksa_go, prga_go;
   logic        init_done, ksa_done, prga_done;
   logic [7:0]  init_addr, init_wrdata, ksa_addr, ksa_wrdata, prga_addr, prga_wrdata;
   logic        init_wren, ksa_wren, prga_wren;
   logic [7:0]  mem_addr, mem_wrdata;
   logic        mem_wren, busy, done, error;
   logic [2:0]  phase;

   rc4_phase_ctrl #(
      .TIMEOUT_CYCLES (TO),
      .RST_CYCLES     (RST_CYC),
      .CNT_W          (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .key         (key),
      .key_q       (key_q),
      .eng_rst_n   (eng_rst_n),
      .init_go     (init_go),
      .ksa_go      (ksa_go),
      .prga_go     (prga_go),
      .init_done   (init_done),
      .ksa_done    (ksa_done),
      .prga_done   (prga_done),
      .init_addr   (init_addr),
      .init_wrdata (init_wrdata),
      .init_wren   (init_wren),
      .ksa_addr    (ksa_addr),
      .ksa_wrdata  (ksa_wrdata),
      .ksa_wren    (ksa_wren),
      .prga_addr   (prga_addr),
      .prga_wrdata (prga_wrdata),
      .prga_wren   (prga_wren),
      .mem_addr    (mem_addr),
      .mem_wrdata  (mem_wrdata),
      .mem_wren    (mem_wren),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .phase       (phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign init_addr = IA; assign init_wrdata = IW; assign init_wren = 1'b1;
   assign ksa_addr  = KA; assign ksa_wrdata  = KW; assign ksa_wren  = 1'b1;
   assign prga_addr = PA; assign prga_wrdata = PW; assign prga_wren = 1'b1;

   // Engine stubs: sticky done after N cycles of go (N=0 never finishes).
   int   init_n, ksa_n, prga_n;
   int   ic, kc, pc;
   logic init_st, ksa_st, prga_st, ksa_force;
   assign init_done = init_st;
   assign ksa_done  = ksa_st | ksa_force;
   assign prga_done = prga_st;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || !eng_rst_n) begin
         ic <= 0; kc <= 0; pc <= 0;
         init_st <= 1'b0; ksa_st <= 1'b0; prga_st <= 1'b0;
      end else begin
         if (init_go) begin ic <= ic + 1; if (ic + 1 == init_n) init_st <= 1'b1; end
         if (ksa_go)  begin kc <= kc + 1; if (kc + 1 == ksa_n)  ksa_st  <= 1'b1; end
         if (prga_go) begin pc <= pc + 1; if (pc + 1 == prga_n) prga_st <= 1'b1; end
      end
   end

   typedef struct {
      phase_e      ph;
      logic [23:0] k;
      int          dur;
   } exp_t;

   exp_t  exp_q[$], probe_q[$];
   string name_q[$], pname_q[$];
   event  probe_ev;
   int    n_cmp = 0;
   int    n_err = 0;

   function automatic logic [2:0] go_of(phase_e p);
      case (p)
         INIT:    return 3'b001;
         KSA:     return 3'b010;
         PRGA:    return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [16:0] mem_of(phase_e p);
      case (p)
         INIT:    return {IA, IW, 1'b1};
         KSA:     return {KA, KW, 1'b1};
         PRGA:    return {PA, PW, 1'b1};
         default: return 17'd0;
      endcase
   endfunction

   // {phase, go, eng_rst_n, busy, done, error, key_q, mem_addr, mem_wrdata, mem_wren}
   function automatic logic [50:0] req_of(phase_e p, logic [23:0] k);
      logic ern, bsy;
      ern = (p != ENG_RST);
      bsy = (p == ENG_RST) || (p == INIT) || (p == KSA) || (p == PRGA);
      return {p, go_of(p), ern, bsy, (p == DONE), (p == ERROR), k, mem_of(p)};
   endfunction

   function automatic logic [50:0] act_of();
      return {phase, prga_go, ksa_go, init_go, eng_rst_n, busy, done, error, key_q,
              mem_addr, mem_wrdata, mem_wren};
   endfunction

   task automatic check(string nm, exp_t e, int got_dur);
      logic [50:0] a, r;
      a = act_of();
      r = req_of(e.ph, e.k);
      n_cmp++;
      if (a !== r || (e.dur >= 0 && got_dur != e.dur)) begin
         n_err++;
         $display("FAIL %s: {ph,go,ern,busy,done,err,key,addr,wd,wren} got %h dur %0d, want %h dur %0d",
                  nm, a, got_dur, r, e.dur);
      end
   endtask

   task automatic push_exp(string nm, phase_e p, logic [23:0] k, int dur);
      exp_t e;
      e.ph = p; e.k = k; e.dur = dur;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic probe(string nm, phase_e p, logic [23:0] k);
      exp_t e;
      e.ph = p; e.k = k; e.dur = -1;
      probe_q.push_back(e);
      pname_q.push_back(nm);
      -> probe_ev;
   endtask

   // Expected transitions of a full run; durations follow from the stub latencies.
   task automatic push_run(string t, logic [23:0] k, int in, int kn, int pn);
      push_exp({t, "_eng_rst"}, ENG_RST, k, -1);
      push_exp({t, "_init"}, INIT, k, RST_CYC);
      push_exp({t, "_ksa"}, KSA, k, in + 1);
      if (kn == 0) begin
         push_exp({t, "_error"}, ERROR, k, TO);
      end else begin
         push_exp({t, "_prga"}, PRGA, k, kn + 1);
         push_exp({t, "_done"}, DONE, k, pn + 1);
      end
   endtask

   task automatic pulse_start(logic [23:0] k);
      @(negedge clk);
      key   = k;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_phase(phase_e p, int budget);
      int n;
      n = 0;
      while (phase !== p && n < budget) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (phase !== p) begin
         n_err++;
         $display("FAIL wait_%s: got phase %0d, want %0d within %0d cycles",
                  p.name(), phase, p, budget);
      end
   endtask

   // Transition monitor plus per-cycle go/restart/mux invariants.
   initial begin : mon_trans
      phase_e last;
      int     run;
      exp_t   e;
      string  nm;
      last = IDLE;
      run  = 0;
      forever begin
         @(negedge clk);
         if (phase !== last) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_transition: got phase %0d, want phase %0d", phase, last);
            end else begin
               e  = exp_q.pop_front();
               nm = name_q.pop_front();
               check(nm, e, run);
            end
            last = phase_e'(phase);
            run  = 1;
         end else begin
            run++;
         end
         n_cmp++;
         if ({prga_go, ksa_go, init_go} !== go_of(phase_e'(phase)) ||
             (!eng_rst_n && {prga_go, ksa_go, init_go} != 3'b000) ||
             {mem_addr, mem_wrdata, mem_wren} !== mem_of(phase_e'(phase))) begin
            n_err++;
            $display("FAIL invariant: got ph %0d go %b ern %b mem %h, want go %b mem %h",
                     phase, {prga_go, ksa_go, init_go}, eng_rst_n,
                     {mem_addr, mem_wrdata, mem_wren}, go_of(phase_e'(phase)),
                     mem_of(phase_e'(phase)));
         end
      end
   end

   initial begin : mon_probe
      exp_t e;
      forever begin
         @(probe_ev);
         while (probe_q.size() > 0) begin
            e = probe_q.pop_front();
            check(pname_q.pop_front(), e, 0);
         end
      end
   end

   initial begin : stim
      rst_n = 1'b1; start = 1'b0; key = '0; ksa_force = 1'b0;
      init_n = 10; ksa_n = 12; prga_n = 5;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1 probe("reset", IDLE, 24'h0);

      // Nominal run; a start mid-KSA must be ignored.
      push_run("A", 24'h000249, init_n, ksa_n, prga_n);
      pulse_start(24'h000249);
      wait_phase(KSA, 40);
      repeat (4) @(negedge clk);
      pulse_start(24'hABCDEF);
      #1 probe("start_while_busy", KSA, 24'h000249);
      wait_phase(DONE, 60);
      repeat (3) @(negedge clk);

      // Restart from DONE; stale ksa_done during INIT; ksa_done on the last watchdog cycle.
      init_n = 10; ksa_n = 15; prga_n = 3;
      push_run("B", 24'h123456, init_n, ksa_n, prga_n);
      ksa_force = 1'b1;
      pulse_start(24'h123456);
      wait_phase(KSA, 40);
      ksa_force = 1'b0;
      wait_phase(DONE, 60);
      repeat (2) @(negedge clk);

      // KSA hangs: watchdog fires.
      init_n = 5; ksa_n = 0; prga_n = 3;
      push_run("C", 24'h5A5A5A, init_n, ksa_n, prga_n);
      pulse_start(24'h5A5A5A);
      wait_phase(ERROR, 60);
      repeat (3) @(negedge clk);

      // Recover from ERROR, then async reset in the middle of PRGA.
      init_n = 4; ksa_n = 6; prga_n = 12;
      push_exp("D_eng_rst", ENG_RST, 24'h000249, -1);
      push_exp("D_init", INIT, 24'h000249, RST_CYC);
      push_exp("D_ksa", KSA, 24'h000249, init_n + 1);
      push_exp("D_prga", PRGA, 24'h000249, ksa_n + 1);
      pulse_start(24'h000249);
      wait_phase(PRGA, 40);
      repeat (3) @(negedge clk);
      push_exp("D_async_idle", IDLE, 24'h0, -1);
      #2 rst_n = 1'b0;
      #1 probe("async_reset", IDLE, 24'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      n_cmp++;
      if (exp_q.size() != 0 || probe_q.size() != 0) begin
         n_err++;
         $display("FAIL leftover_expectations: got %0d pending, want 0",
                  exp_q.size() + probe_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rc4_phase_ctrl.md
Name: rc4_phase_ctrl

Overview:
Top-level sequencer for the RC4 decrypt datapath. It runs three engines in strict order over the single-port 256x8 S-memory: init (s[i]=i), KSA swap loop, then PRGA/decode. It owns the go/done handshake to each engine and the engine restart, and it muxes the S-memory write/address port to whichever engine is active. A per-phase watchdog flags a hung engine.

Parameters:
TIMEOUT_CYCLES, 4096, max cycles a phase may stay active before ERROR (KSA needs about 2048).
RST_CYCLES, 2, cycles eng_rst_n is held low on each (re)start; must be >= 1.
CNT_W, 16, watchdog/cycle counter width; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to run with key; accepted only in IDLE, DONE or ERROR
key  in  24  secret key; latched on accepted start
key_q  out  24  latched key, fanned out to KSA/PRGA engines
eng_rst_n  out  1  registered active-low restart to all three engines
init_go / ksa_go / prga_go  out  1 each  level enables; one-hot or all zero
init_done / ksa_done / prga_done  in  1 each  sticky done flags from engines
init_addr, ksa_addr, prga_addr  in  8 each  engine memory addresses
init_wrdata, ksa_wrdata, prga_wrdata  in  8 each  engine write data
init_wren, ksa_wren, prga_wren  in  1 each  engine write enables
mem_addr  out  8  to S-memory
mem_wrdata  out  8  to S-memory
mem_wren  out  1  to S-memory; S-memory rddata goes straight to all engines, not through this block
busy  out  1  high from accepted start until DONE or ERROR
done  out  1  high in DONE
error  out  1  high in ERROR
phase  out  3  current state encoding (rc4_pkg::phase_e)

Behaviour:
- Reset (async, rst_n=0) gives state IDLE, key_q=0, eng_rst_n=1, all go=0, busy=0, done=0, error=0, counter=0.
- All control outputs are registered.
- The mem_* mux is combinational on registered state:
  - INIT selects init_*, KSA selects ksa_*, PRGA selects prga_*.
  - Any other state drives addr=0, wrdata=0, wren=0.
- States and transitions:
  - IDLE: on start, latch key_q=key, set busy=1, load counter, go to ENG_RST.
  - ENG_RST: eng_rst_n=0 for exactly RST_CYCLES cycles, then eng_rst_n=1 and go to INIT with init_go=1 and counter=0.
  - INIT: on init_done go to KSA, with init_go=0, ksa_go=1 in the same register update and counter=0.
  - KSA: on ksa_done go to PRGA, with ksa_go=0, prga_go=1 and counter=0.
  - PRGA: on prga_done go to DONE, with prga_go=0, busy=0, done=1.
  - DONE: holds. start clears done and starts a new run exactly as from IDLE. Engines are restarted via ENG_RST because their done flags are sticky.
  - ERROR: holds; all go=0, busy=0, error=1. start clears error and restarts as from IDLE.
- Watchdog:
  - Counter increments every cycle in INIT/KSA/PRGA and clears on phase entry.
  - When counter == TIMEOUT_CYCLES-1 and the active done is low: next state ERROR, go=0.
  - Same-cycle done and timeout: done wins.
- Done inputs from non-active engines are ignored, e.g. stale ksa_done high during INIT does not skip INIT.
- A go line is never high together with eng_rst_n=0.
- start while busy is ignored, and key_q does not change.
- No phase-to-phase bubble is required. A one-cycle gap in which mem_wren=0 is permitted but not required.
- Async reset mid-phase: all outputs return to reset values immediately, and mem_wren=0 combinationally.

Decomposition:
- rc4_pkg holds:
  - typedef enum logic[2:0] phase_e {IDLE, ENG_RST, INIT, KSA, PRGA, DONE, ERROR}
  - localparams KEY_W=24, ADDR_W=8, DATA_W=8
- One natural sub-module: rc4_mem_mux, the purely combinational 3:1 port mux with default-zero, selected by phase_e.
- The FSM and watchdog stay in rc4_phase_ctrl.

Test Plan:
1. Nominal: key=24'h000249, start pulse; stub engines assert done after 256 / 1536 / 64 cycles. Require:
   - eng_rst_n low exactly 2 cycles
   - go lines one-hot in order INIT, KSA, PRGA
   - done=1 after the final done, busy=0, key_q=24'h000249.
2. Mux routing: in each phase, drive a distinct pattern on each engine (e.g. init 8'h11, ksa 8'h22, prga 8'h33, each wren=1). Require mem_addr/wrdata equal only the active engine's values; IDLE and DONE show 0/0/0.
3. Watchdog: TIMEOUT_CYCLES=16, ksa_done never asserts. Require ERROR exactly 16 cycles after KSA entry, error=1, ksa_go=0, mem_wren=0. Then start recovers via ENG_RST.
4. Boundary: assert ksa_done in the same cycle the counter hits 15. Require PRGA, not ERROR. Also hold ksa_done high during INIT and require no skip.
5. start ignored while busy: start with key=24'hABCDEF mid-KSA leaves key_q and phase unchanged. After DONE, start with 24'h123456 gives key_q=24'h123456 and eng_rst_n low for 2 cycles.
6. Async reset mid-PRGA: drop rst_n between clock edges. Require all outputs at reset values immediately and phase=IDLE.
